// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the I-cache refill controller and the fetch stage, cache arrays and memory bus.
// The master modport is the controller side; the slave modport is its environment.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              hit;
    logic              miss_stall;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [31:0]       fill_data;
    logic              tag_we;

    modport master (
        input  fetch_valid, fetch_addr, hit, mem_gnt, mem_rvalid, mem_rdata,
        output miss_stall, mem_req, mem_addr, fill_we, fill_addr, fill_data, tag_we
    );

    modport slave (
        output fetch_valid, fetch_addr, hit, mem_gnt, mem_rvalid, mem_rdata,
        input  miss_stall, mem_req, mem_addr, fill_we, fill_addr, fill_data, tag_we
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill controller: stalls fetch on a miss, bursts one line from memory and commits the tag.
// Define ICACHE_PERF_CNT_EN to add the perf_miss_cnt / perf_stall_cnt performance counters.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icache_refill_ctrl_if.master  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_miss_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  line_base;
    logic               mem_req_q;
    logic               tag_we_q;
    logic               miss_start;
    logic               fill_fire;

    assign miss_start = (state == IDLE) && bus.fetch_valid && !bus.hit;
    assign fill_fire  = (state == FILL) && bus.mem_rvalid;

    // A started refill always runs to COMMIT; there is no abort path for redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            line_base <= '0;
            mem_req_q <= 1'b0;
            tag_we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        line_base <= bus.fetch_addr & ~LINE_MASK;
                        cnt       <= '0;
                        mem_req_q <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_rvalid) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(LINE_WORDS - 1)) begin
                            tag_we_q <= 1'b1;
                            state    <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    tag_we_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    tag_we_q  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The IDLE miss term is combinational so the missing fetch never enters IF-ID.
    assign bus.miss_stall = miss_start || (state != IDLE);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = line_base;
    assign bus.tag_we     = tag_we_q;
    assign bus.fill_we    = fill_fire;
    assign bus.fill_addr  = fill_fire ? (line_base | ADDR_W'({cnt, 2'b00})) : '0;
    assign bus.fill_data  = fill_fire ? bus.mem_rdata : 32'h0;

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_miss_cnt  <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (miss_start) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
            if (bus.miss_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: vector table, directed refill sequences and a random run
// against a transaction-level model of the refill.
module tb_icache_refill_ctrl;

    localparam int LW = 4;
    localparam logic [31:0] LMASK = 32'(LW * 4 - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   assert_count = 0;
    int   fail_count = 0;

    icache_refill_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_miss_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    icache_refill_ctrl #(
        .LINE_WORDS(LW),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_miss_cnt(perf_miss_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        hit;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_maddr;
        logic        e_fwe;
        logic [31:0] e_faddr;
        logic [31:0] e_fdata;
        logic        e_twe;
    } vec_t;

    vec_t vecs[8];

    task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic h,
                                 input logic g, input logic rv, input logic [31:0] rd);
        bus.fetch_valid = fv;
        bus.fetch_addr  = fa;
        bus.hit         = h;
        bus.mem_gnt     = g;
        bus.mem_rvalid  = rv;
        bus.mem_rdata   = rd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
    endtask

    // Drives one complete miss; the cache model flips hit once the tag commit is seen.
    task automatic runMiss(input logic [31:0] addr, input int gnt_delay, input int gap_at,
                           output int stalls, output int writes, output int req_cycles);
        logic [31:0] base;
        int          beats_sent;
        int          idx;
        int          last_beat;
        int          tag_cycle;
        int          tags;
        bit          gap_done;
        bit          line_valid;
        bit          done;
        logic        rv;
        logic [31:0] rd;
        base = addr & ~LMASK;
        beats_sent = 0;
        last_beat = -1;
        tag_cycle = -1;
        tags = 0;
        gap_done = 1'b0;
        line_valid = 1'b0;
        done = 1'b0;
        stalls = 0;
        writes = 0;
        req_cycles = 0;
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("detect_stall", {31'h0, bus.miss_stall}, 32'h1);
        nextCycle();
        for (int c = 0; c < 64 && !done; c++) begin
            rv = 1'b0;
            rd = 32'h0;
            idx = beats_sent;
            if (c > gnt_delay && beats_sent < LW) begin
                if (beats_sent == gap_at && !gap_done) begin
                    gap_done = 1'b1;
                end else begin
                    rv = 1'b1;
                    rd = 32'hA0 + 32'(beats_sent);
                    beats_sent++;
                end
            end
            applyStimulus(1'b1, addr, line_valid, c == gnt_delay, rv, rd);
            @(negedge clk);
            if (line_valid && !bus.miss_stall) begin
                done = 1'b1;
            end
            if (bus.miss_stall) stalls++;
            if (bus.mem_req) begin
                req_cycles++;
                checkOutput("mem_addr_stable", bus.mem_addr, base);
            end
            checkOutput("fill_we", {31'h0, bus.fill_we}, {31'h0, rv});
            if (rv) begin
                checkOutput("fill_addr", bus.fill_addr, base + 32'(4 * idx));
                checkOutput("fill_data", bus.fill_data, rd);
                last_beat = c;
            end
            if (bus.fill_we) writes++;
            if (bus.tag_we) begin
                tags++;
                tag_cycle = c;
                line_valid = 1'b1;
            end
            nextCycle();
        end
        checkOutput("refill_completes", {31'h0, done}, 32'h1);
        checkOutput("tag_we_count", 32'(tags), 32'h1);
        checkOutput("tag_after_last_beat", 32'(tag_cycle), 32'(last_beat + 1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          stalls;
        int          writes;
        int          req_cycles;
        logic        m_active;
        logic        m_granted;
        int          m_beats;
        logic [31:0] m_base;
        logic        fv, h, g, rv;
        logic [31:0] fa, rd;
        logic        e_stall, e_req, e_fwe, e_twe;

        vecs[0] = '{1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,  1'b0};
        vecs[1] = '{1'b1, 32'h1234, 1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1, 32'h1230, 1'b0, 32'h0,    32'h0,  1'b0};
        vecs[2] = '{1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 32'hA0,   1'b1, 1'b0, 32'h0,    1'b1, 32'h1230, 32'hA0, 1'b0};
        vecs[3] = '{1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 32'hA1,   1'b1, 1'b0, 32'h0,    1'b1, 32'h1234, 32'hA1, 1'b0};
        vecs[4] = '{1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 32'hA2,   1'b1, 1'b0, 32'h0,    1'b1, 32'h1238, 32'hA2, 1'b0};
        vecs[5] = '{1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 32'hA3,   1'b1, 1'b0, 32'h0,    1'b1, 32'h123C, 32'hA3, 1'b0};
        vecs[6] = '{1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,  1'b1};
        vecs[7] = '{1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,  1'b0};

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("reset_miss_stall", {31'h0, bus.miss_stall}, 32'h0);
        checkOutput("reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
        checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset_fill_we", {31'h0, bus.fill_we}, 32'h0);
        checkOutput("reset_tag_we", {31'h0, bus.tag_we}, 32'h0);
        doReset();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput("hit_stall", {31'h0, bus.miss_stall}, 32'h0);
            checkOutput("hit_mem_req", {31'h0, bus.mem_req}, 32'h0);
            checkOutput("hit_fill_we", {31'h0, bus.fill_we}, 32'h0);
            nextCycle();
        end

        // Single miss with immediate grant; stray beats in IDLE, REQ and COMMIT must not write.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].fv, vecs[i].fa, vecs[i].hit, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_stall", i), {31'h0, bus.miss_stall}, {31'h0, vecs[i].e_stall});
            checkOutput($sformatf("vec%0d_req", i), {31'h0, bus.mem_req}, {31'h0, vecs[i].e_req});
            checkOutput($sformatf("vec%0d_fill_we", i), {31'h0, bus.fill_we}, {31'h0, vecs[i].e_fwe});
            checkOutput($sformatf("vec%0d_tag_we", i), {31'h0, bus.tag_we}, {31'h0, vecs[i].e_twe});
            if (vecs[i].e_req)
                checkOutput($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
            if (vecs[i].e_fwe) begin
                checkOutput($sformatf("vec%0d_fill_addr", i), bus.fill_addr, vecs[i].e_faddr);
                checkOutput($sformatf("vec%0d_fill_data", i), bus.fill_data, vecs[i].e_fdata);
            end
            nextCycle();
        end

        runMiss(32'h0000_1234, 0, -1, stalls, writes, req_cycles);
        checkOutput("single_stalls", 32'(stalls), 32'd6);
        checkOutput("single_writes", 32'(writes), 32'd4);

        runMiss(32'h0000_4008, 5, 2, stalls, writes, req_cycles);
        checkOutput("delayed_stalls", 32'(stalls), 32'd12);
        checkOutput("delayed_writes", 32'(writes), 32'd4);
        checkOutput("delayed_req_cycles", 32'(req_cycles), 32'd6);

        // Reset asserted in the middle of the beat-2 write.
        applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h3004, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0, 1'b1, 32'hB0);
        nextCycle();
        applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0, 1'b1, 32'hB1);
        nextCycle();
        applyStimulus(1'b0, 32'h3004, 1'b0, 1'b0, 1'b1, 32'hB2);
        @(negedge clk);
        checkOutput("pre_reset_fill_we", {31'h0, bus.fill_we}, 32'h1);
        checkOutput("pre_reset_fill_addr", bus.fill_addr, 32'h3008);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        checkOutput("rst_fill_we", {31'h0, bus.fill_we}, 32'h0);
        checkOutput("rst_tag_we", {31'h0, bus.tag_we}, 32'h0);
        checkOutput("rst_miss_stall", {31'h0, bus.miss_stall}, 32'h0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_fill_addr", bus.fill_addr, 32'h0);
        checkOutput("rst_fill_data", bus.fill_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB3);
        @(negedge clk);
        checkOutput("post_rst_stray_beat", {31'h0, bus.fill_we}, 32'h0);
        checkOutput("post_rst_stall", {31'h0, bus.miss_stall}, 32'h0);
        nextCycle();
        runMiss(32'h0000_5000, 0, -1, stalls, writes, req_cycles);
        checkOutput("post_rst_stalls", 32'(stalls), 32'd6);
        checkOutput("post_rst_writes", 32'(writes), 32'd4);

`ifdef ICACHE_PERF_CNT_EN
        doReset();
        checkOutput("perf_miss_reset", perf_miss_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            runMiss(32'h0000_6000 + 32'(i * 64), 0, -1, stalls, writes, req_cycles);
        end
        checkOutput("perf_miss_cnt", perf_miss_cnt, 32'd3);
        checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd21);
`endif

        // Random traffic against a transaction-level view of one outstanding refill.
        doReset();
        m_active = 1'b0;
        m_granted = 1'b0;
        m_beats = 0;
        m_base = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            fv = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 3) != 0);
            fa = $urandom;
            g  = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 4) != 0);
            rd = $urandom;
            applyStimulus(fv, fa, h, g, rv, rd);
            @(negedge clk);
            e_stall = m_active || (fv && !h);
            e_req   = m_active && !m_granted;
            e_twe   = m_active && (m_beats == LW);
            e_fwe   = m_active && m_granted && (m_beats < LW) && rv;
            checkOutput("rand_stall", {31'h0, bus.miss_stall}, {31'h0, e_stall});
            checkOutput("rand_req", {31'h0, bus.mem_req}, {31'h0, e_req});
            checkOutput("rand_fill_we", {31'h0, bus.fill_we}, {31'h0, e_fwe});
            checkOutput("rand_tag_we", {31'h0, bus.tag_we}, {31'h0, e_twe});
            if (e_req) checkOutput("rand_mem_addr", bus.mem_addr, m_base);
            if (e_fwe) begin
                checkOutput("rand_fill_addr", bus.fill_addr, m_base + 32'(4 * m_beats));
                checkOutput("rand_fill_data", bus.fill_data, rd);
            end
            if (!m_active) begin
                if (fv && !h) begin
                    m_active = 1'b1;
                    m_granted = 1'b0;
                    m_beats = 0;
                    m_base = fa & ~LMASK;
                end
            end else if (e_twe) begin
                m_active = 1'b0;
            end else if (!m_granted) begin
                m_granted = g;
            end else if (rv) begin
                m_beats++;
            end
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
